// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_CHK,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_W          = 8 * LEN_BYTES;

   // True when a frame of len words fits in a RAM of 2**addr_w words.
   function automatic logic len_fits(input logic [LEN_W-1:0] len, input int addr_w);
      return {16'd0, len} <= (32'd1 << addr_w);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-in / RAM-write / status bundle of the instruction-memory loader.
interface imem_loader_if #(
   parameter int ADDR_W = 14
) ();
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   word_count;

   modport master (
      output start, rx_data, rx_valid,
      input  wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, word_count
   );

   modport slave (
      input  start, rx_data, rx_valid,
      output wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, word_count
   );
endinterface

// File: rtl/imem_loader_word_asm.sv
// Packs a stream of bytes into big-endian 32-bit words (first byte -> [31:24]).
// word_last flags that the next push completes a word; word/word_ready are
// registered and present the finished word for exactly one cycle.
module loader_word_asm
   import imem_loader_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        push,
   input  logic [7:0]  byte_in,
   output logic        word_last,
   output logic [31:0] word,
   output logic        word_ready
);

   localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_WORD - 1);
   localparam logic [1:0] IDX_ONE  = 2'd1;

   logic [1:0]  idx_q, idx_d;
   logic [23:0] shift_q, shift_d;
   logic [31:0] word_q, word_d;
   logic        ready_q, ready_d;

   // Next-state: shift bytes in, emit the word on the last byte.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      idx_d   = idx_q;
      shift_d = shift_q;
      word_d  = word_q;
      ready_d = 1'b0;
      if (clear) begin
         idx_d   = '0;
         shift_d = '0;
      end else if (push) begin
         if (idx_q == IDX_LAST) begin
            word_d  = {shift_q, byte_in};
            ready_d = 1'b1;
            idx_d   = '0;
         end else begin
            shift_d = {shift_q[15:0], byte_in};
            idx_d   = idx_q + IDX_ONE;
         end
      end
   end

   // State registers.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: async active-low reset clears every flop; state updates use non-blocking assignments only.
      if (!reset) begin
         idx_q   <= '0;
         shift_q <= '0;
         word_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         ready_q <= ready_d;
      end
   end

   assign word_last  = (idx_q == IDX_LAST);
   assign word       = word_q;
   assign word_ready = ready_q;

endmodule

// File: rtl/imem_loader.sv
// UART-to-instruction-RAM programmer. Frame: 16-bit big-endian word count N,
// then 4*N data bytes; words are written from address 0 while the CPU is held
// in reset. Optional trailer checksum (XOR of data bytes) enabled by defining
// IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W      = 14,
   parameter int TIMEOUT_CYC = 2_000_000
) (
   input logic          clock,
   input logic          reset,
   imem_loader_if.slave bus
);

   localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = 1;
   localparam logic [ADDR_W:0]  CNT_ONE  = 1;

   state_e             state_q, state_d;
   logic [7:0]         len_hi_q, len_hi_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [ADDR_W:0]    word_count_q, word_count_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               cpu_hold_q, cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]         chk_q, chk_d;
`endif

   logic               loading, all_words, byte_taken, take_start;
   logic [LEN_W-1:0]   new_len;
   logic               asm_push, asm_last, asm_ready;
   logic [31:0]        asm_word;

   assign new_len = {len_hi_q, bus.rx_data};

   loader_word_asm u_word_asm (
      .clock      (clock),
      .reset      (reset),
      .clear      (take_start),
      .push       (asm_push),
      .byte_in    (bus.rx_data),
      .word_last  (asm_last),
      .word       (asm_word),
      .word_ready (asm_ready)
   );

   // Session FSM, counters and status next-state.
   always_comb begin
      state_d      = state_q;
      len_hi_d     = len_hi_q;
      len_d        = len_q;
      wr_addr_d    = wr_addr_q;
      word_count_d = word_count_q;
      busy_d       = busy_q;
      done_d       = done_q;
      err_d        = err_q;
      cpu_hold_d   = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_d        = chk_q;
`endif
      asm_push     = 1'b0;

      loading    = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHK};
      all_words  = 32'(word_count_q) == 32'(len_q);
      byte_taken = bus.rx_valid && loading && !(state_q == ST_DATA && all_words);
      take_start = bus.start && !loading;
      tmo_d      = loading ? tmo_q + TMO_ONE : '0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            // A coincident byte is dropped: only start is acted on here.
            if (take_start) begin
               state_d      = ST_LEN_HI;
               busy_d       = 1'b1;
               cpu_hold_d   = 1'b1;
               done_d       = 1'b0;
               err_d        = 1'b0;
               word_count_d = '0;
               wr_addr_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk_d        = '0;
`endif
            end
         end
         ST_LEN_HI: begin
            if (bus.rx_valid) begin
               len_hi_d = bus.rx_data;
               state_d  = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (bus.rx_valid) begin
               len_d = new_len;
               if (!len_fits(new_len, ADDR_W)) begin
                  state_d = ST_ERR;
               end else if (new_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (byte_taken) begin
               asm_push = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk_d = chk_q ^ bus.rx_data;
`endif
               if (asm_last) begin
                  // Address/count move with the byte that completes the word,
                  // so they are valid alongside the registered write strobe.
                  wr_addr_d    = word_count_q[ADDR_W-1:0];
                  word_count_d = word_count_q + CNT_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  if (32'(word_count_q + CNT_ONE) == 32'(len_q)) state_d = ST_CHK;
`endif
               end
            end
`ifndef IMEM_LOADER_CHECKSUM_EN
            // all_words first holds in the write-strobe cycle of the last word.
            else if (all_words) begin
               state_d = ST_DONE;
            end
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (bus.rx_valid) state_d = (bus.rx_data == chk_q) ? ST_DONE : ST_ERR;
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      if (byte_taken) begin
         tmo_d = '0;
      end else if (loading && tmo_q == TMO_LAST && state_d == state_q) begin
         state_d = ST_ERR;
      end

      if (state_d == ST_DONE && state_q != ST_DONE) begin
         done_d     = 1'b1;
         busy_d     = 1'b0;
         cpu_hold_d = 1'b0;
      end
      if (state_d == ST_ERR && state_q != ST_ERR) begin
         err_d  = 1'b1;
         busy_d = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         len_hi_q     <= '0;
         len_q        <= '0;
         wr_addr_q    <= '0;
         word_count_q <= '0;
         tmo_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         cpu_hold_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         len_hi_q     <= len_hi_d;
         len_q        <= len_d;
         wr_addr_q    <= wr_addr_d;
         word_count_q <= word_count_d;
         tmo_q        <= tmo_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         cpu_hold_q   <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk_q        <= chk_d;
`endif
      end
   end

   assign bus.wr_en      = asm_ready;
   assign bus.wr_data    = asm_word;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.word_count = word_count_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected RAM writes are queued as each
// word's last byte is driven and compared when wr_en fires.
module tb_imem_loader;

   localparam int ADDR_W = 4;
   localparam int TMO    = 64;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic clock = 1'b0;
   logic reset = 1'b0;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_writes = 0;
   wr_t         exp_q[$];
   logic [31:0] words[$];
   logic [7:0]  chk_acc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Write monitor / scoreboard.
   always @(negedge clock) begin : mon
      wr_t e;
      if (reset && bus.wr_en) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
            check("wr_data", 64'(bus.wr_data), 64'(e.data));
            check("wr_count", 64'(bus.word_count), 64'(e.addr) + 1);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b);
      idle(2);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clock);
      bus.rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clock);
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic send_len(input int n);
      send_byte(8'(n >> 8));
      send_byte(8'(n));
   endtask

   task automatic send_data(input int n);
      logic [31:0] w;
      for (int k = 0; k < n; k++) begin
         w = words[k];
         send_byte(w[31:24]);
         send_byte(w[23:16]);
         send_byte(w[15:8]);
         exp_q.push_back(wr_t'{addr: ADDR_W'(k), data: w});
         send_byte(w[7:0]);
         chk_acc = chk_acc ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      end
   endtask

   task automatic send_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(chk_acc);
`endif
   endtask

   task automatic send_frame(input int n);
      chk_acc = 8'h00;
      send_len(n);
      send_data(n);
      send_trailer();
   endtask

   task automatic fill_words(input int n);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back($urandom);
   endtask

   task automatic wait_end(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (bus.done || bus.err) break;
         @(negedge clock);
      end
      check(tag, 64'(bus.done | bus.err), 1);
   endtask

   task automatic check_status(input string tag, input logic e_busy, input logic e_done,
                               input logic e_err, input logic e_hold, input int e_wc);
      check({tag, "_busy"}, 64'(bus.busy), 64'(e_busy));
      check({tag, "_done"}, 64'(bus.done), 64'(e_done));
      check({tag, "_err"}, 64'(bus.err), 64'(e_err));
      check({tag, "_hold"}, 64'(bus.cpu_hold), 64'(e_hold));
      check({tag, "_wc"}, 64'(bus.word_count), 64'(e_wc));
   endtask

   task automatic check_bus_zero(input string tag);
      check({tag, "_wr"}, {bus.wr_en, bus.wr_addr, bus.wr_data}, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int w0;
      bus.start    = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      // Reset state
      idle(2);
      check_status("rst", 0, 0, 0, 0, 0);
      check_bus_zero("rst");
      reset = 1'b1;

      // 1: two-word frame
      exp_q.delete();
      words = '{32'h2408_0005, 32'h0000_0008};
      w0 = n_writes;
      pulse_start();
      check_status("t1_start", 1, 0, 0, 1, 0);
      send_frame(2);
      wait_end("t1_end", 50);
      check_status("t1", 0, 1, 0, 0, 2);
      check("t1_writes", 64'(n_writes - w0), 2);
      check("t1_pending", 64'(exp_q.size()), 0);

      // 2: empty frame
      words.delete();
      w0 = n_writes;
      pulse_start();
      check_status("t2_start", 1, 0, 0, 1, 0);
      send_frame(0);
      wait_end("t2_end", 50);
      check_status("t2", 0, 1, 0, 0, 0);
      check("t2_writes", 64'(n_writes - w0), 0);

      // 3: timeout with a partial word
      w0 = n_writes;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'hBB);
      idle(TMO - 10);
      check_status("t3_wait", 1, 0, 0, 1, 0);
      wait_end("t3_end", 40);
      check_status("t3", 0, 0, 1, 1, 0);
      check("t3_writes", 64'(n_writes - w0), 0);

      // 4: length bound (2**ADDR_W = 16)
      w0 = n_writes;
      pulse_start();
      check_status("t4_start", 1, 0, 0, 1, 0);
      send_len(17);
      check_status("t4_len17", 0, 0, 1, 1, 0);
      exp_q.delete();
      fill_words(16);
      pulse_start();
      send_frame(16);
      wait_end("t4_end", 100);
      check_status("t4", 0, 1, 0, 0, 16);
      check("t4_writes", 64'(n_writes - w0), 16);
      check("t4_pending", 64'(exp_q.size()), 0);

      // 5: reset mid-word, then a clean reload
      fill_words(3);
      pulse_start();
      send_len(3);
      send_byte(words[0][31:24]);
      send_byte(words[0][23:16]);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_status("t5_rst", 0, 0, 0, 0, 0);
      check_bus_zero("t5_rst");
      idle(2);
      reset = 1'b1;
      exp_q.delete();
      w0 = n_writes;
      pulse_start();
      send_frame(3);
      wait_end("t5_end", 100);
      check_status("t5", 0, 1, 0, 0, 3);
      check("t5_writes", 64'(n_writes - w0), 3);

      // 6a: start while busy is ignored
      fill_words(1);
      exp_q.delete();
      w0 = n_writes;
      pulse_start();
      chk_acc = 8'h00;
      send_len(1);
      pulse_start();
      check_status("t6_busy", 1, 0, 0, 1, 0);
      send_data(1);
      send_trailer();
      wait_end("t6a_end", 50);
      check_status("t6a", 0, 1, 0, 0, 1);
      check("t6a_writes", 64'(n_writes - w0), 1);

      // 6b: byte coincident with start in IDLE is dropped
      pulse_reset();
      exp_q.delete();
      fill_words(1);
      w0 = n_writes;
      @(negedge clock);
      bus.start    = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h00;
      @(negedge clock);
      bus.start    = 1'b0;
      bus.rx_valid = 1'b0;
      send_frame(1);
      wait_end("t6b_end", 50);
      check_status("t6b", 0, 1, 0, 0, 1);
      check("t6b_writes", 64'(n_writes - w0), 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // 6c: wrong trailer
      fill_words(2);
      exp_q.delete();
      pulse_start();
      chk_acc = 8'h00;
      send_len(2);
      send_data(2);
      send_byte(chk_acc ^ 8'hFF);
      wait_end("t6c_end", 50);
      check_status("t6c", 0, 0, 1, 1, 2);
`endif

      idle(4);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
